// File: rtl/decode_issue_queue_pkg.sv
// Shared decode constants: RISC-V major opcodes, inside opcode codes and the decoded-instruction bundle.
package decode_issue_queue_pkg;

  localparam int INSTR_W   = 32;
  localparam int REG_IDX_W = 5;
  localparam int OP_W      = 6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [OP_W-1:0] {
    OP_NOP,  OP_LUI,  OP_AUIPC, OP_JAL,  OP_JALR,
    OP_BEQ,  OP_BNE,  OP_BLT,   OP_BGE,  OP_BLTU, OP_BGEU,
    OP_LB,   OP_LH,   OP_LW,    OP_LBU,  OP_LHU,
    OP_SB,   OP_SH,   OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,  OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD,  OP_SUB,  OP_SLL,   OP_SLT,  OP_SLTU, OP_XOR,
    OP_SRL,  OP_SRA,  OP_OR,    OP_AND
  } op_t;

  typedef struct packed {
    op_t                op;
    logic               slb;
    logic [INSTR_W-1:0] imm;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               writes_rd;
    logic               illegal;
  } dec_t;

endpackage

// File: rtl/decode_issue_queue_decode_core.sv
// Combinational RV32I decoder: instruction word to inside opcode, target unit, immediate and source/dest usage.
module decode_core
  import decode_issue_queue_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output dec_t               o_dec
);

  logic [6:0]         w_opc;
  logic [2:0]         w_f3;
  logic               w_alt;
  logic [INSTR_W-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;

  assign w_opc    = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_alt    = i_instr[30];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b  = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u  = {i_instr[31:12], 12'b0};
  assign w_imm_j  = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign w_imm_sh = {27'b0, i_instr[24:20]};

  always_comb begin
    o_dec    = '0;
    o_dec.op = OP_NOP;
    case (w_opc)
      OPC_LUI:   begin o_dec.op = OP_LUI;   o_dec.imm = w_imm_u; o_dec.writes_rd = 1'b1; end
      OPC_AUIPC: begin o_dec.op = OP_AUIPC; o_dec.imm = w_imm_u; o_dec.writes_rd = 1'b1; end
      OPC_JAL:   begin o_dec.op = OP_JAL;   o_dec.imm = w_imm_j; o_dec.writes_rd = 1'b1; end
      OPC_JALR: begin
        o_dec.op = OP_JALR; o_dec.imm = w_imm_i;
        o_dec.uses_rs1 = 1'b1; o_dec.writes_rd = 1'b1;
        o_dec.illegal = (w_f3 != 3'd0);
      end
      OPC_BRANCH: begin
        o_dec.imm = w_imm_b; o_dec.uses_rs1 = 1'b1; o_dec.uses_rs2 = 1'b1;
        case (w_f3)
          3'd0:    o_dec.op = OP_BEQ;
          3'd1:    o_dec.op = OP_BNE;
          3'd4:    o_dec.op = OP_BLT;
          3'd5:    o_dec.op = OP_BGE;
          3'd6:    o_dec.op = OP_BLTU;
          3'd7:    o_dec.op = OP_BGEU;
          default: o_dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        o_dec.slb = 1'b1; o_dec.imm = w_imm_i;
        o_dec.uses_rs1 = 1'b1; o_dec.writes_rd = 1'b1;
        case (w_f3)
          3'd0:    o_dec.op = OP_LB;
          3'd1:    o_dec.op = OP_LH;
          3'd2:    o_dec.op = OP_LW;
          3'd4:    o_dec.op = OP_LBU;
          3'd5:    o_dec.op = OP_LHU;
          default: o_dec.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        o_dec.slb = 1'b1; o_dec.imm = w_imm_s;
        o_dec.uses_rs1 = 1'b1; o_dec.uses_rs2 = 1'b1;
        case (w_f3)
          3'd0:    o_dec.op = OP_SB;
          3'd1:    o_dec.op = OP_SH;
          3'd2:    o_dec.op = OP_SW;
          default: o_dec.illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        o_dec.imm = w_imm_i; o_dec.uses_rs1 = 1'b1; o_dec.writes_rd = 1'b1;
        case (w_f3)
          3'd0: o_dec.op = OP_ADDI;
          3'd2: o_dec.op = OP_SLTI;
          3'd3: o_dec.op = OP_SLTIU;
          3'd4: o_dec.op = OP_XORI;
          3'd6: o_dec.op = OP_ORI;
          3'd7: o_dec.op = OP_ANDI;
          3'd1: begin o_dec.op = OP_SLLI; o_dec.imm = w_imm_sh; end
          default: begin o_dec.op = w_alt ? OP_SRAI : OP_SRLI; o_dec.imm = w_imm_sh; end
        endcase
      end
      OPC_OP: begin
        o_dec.uses_rs1 = 1'b1; o_dec.uses_rs2 = 1'b1; o_dec.writes_rd = 1'b1;
        case (w_f3)
          3'd0:    o_dec.op = w_alt ? OP_SUB : OP_ADD;
          3'd1:    o_dec.op = OP_SLL;
          3'd2:    o_dec.op = OP_SLT;
          3'd3:    o_dec.op = OP_SLTU;
          3'd4:    o_dec.op = OP_XOR;
          3'd5:    o_dec.op = w_alt ? OP_SRA : OP_SRL;
          3'd6:    o_dec.op = OP_OR;
          default: o_dec.op = OP_AND;
        endcase
      end
      default: o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_issue_queue.sv
// Instruction queue + decode/rename/dispatch; head issues combinationally (0-cycle head-to-issue), stalls on ROB/RS/SLB full.
// Build option DECODE_CDB_BYPASS_EN: capture a same-cycle CDB broadcast for a still-pending source.
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int IQ_DEPTH  = 8,
  parameter int ROB_TAG_W = 4,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 in_fetch_valid,
  input  logic [XLEN-1:0]      in_fetch_instr,
  input  logic [XLEN-1:0]      in_fetch_pc,
  input  logic                 in_fetch_jump,
  output logic                 out_fetch_ready,
  output logic [4:0]           out_reg_rs1,
  output logic [4:0]           out_reg_rs2,
  input  logic [XLEN-1:0]      in_reg_value1,
  input  logic [XLEN-1:0]      in_reg_value2,
  input  logic                 in_reg_busy1,
  input  logic                 in_reg_busy2,
  input  logic [ROB_TAG_W-1:0] in_reg_robtag1,
  input  logic [ROB_TAG_W-1:0] in_reg_robtag2,
  output logic [ROB_TAG_W-1:0] out_rob_tag1,
  output logic [ROB_TAG_W-1:0] out_rob_tag2,
  input  logic [XLEN-1:0]      in_rob_value1,
  input  logic [XLEN-1:0]      in_rob_value2,
  input  logic                 in_rob_ready1,
  input  logic                 in_rob_ready2,
  input  logic [ROB_TAG_W-1:0] in_rob_freetag,
  input  logic                 in_rob_full,
  input  logic                 in_rs_full,
  input  logic                 in_slb_full,
  input  logic                 in_cdb_valid,
  input  logic [ROB_TAG_W-1:0] in_cdb_tag,
  input  logic [XLEN-1:0]      in_cdb_value,
  output logic                 out_issue_valid,
  output logic                 out_issue_slb,
  output logic [OP_W-1:0]      out_op,
  output logic [XLEN-1:0]      out_value1,
  output logic [XLEN-1:0]      out_value2,
  output logic [ROB_TAG_W-1:0] out_tag1,
  output logic [ROB_TAG_W-1:0] out_tag2,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_pc,
  output logic [4:0]           out_rd,
  output logic [ROB_TAG_W-1:0] out_rob_tag,
  output logic                 out_jump
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic               jump;
  } iq_entry_t;

  typedef struct packed {
    logic [XLEN-1:0]      val;
    logic [ROB_TAG_W-1:0] tag;
  } opnd_t;

  iq_entry_t        r_mem [IQ_DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;

  iq_entry_t w_head;
  dec_t      w_dec;
  opnd_t     w_src1, w_src2;
  logic      w_enq, w_deq, w_head_vld, w_unit_full, w_issue;

  // Ready uses the pre-edge count, so a full queue never accepts even while it dequeues.
  assign out_fetch_ready = (r_count != CNT_W'(IQ_DEPTH)) && !flush && rdy && !rst;
  assign w_enq           = in_fetch_valid && out_fetch_ready;

  assign w_head = r_mem[r_head];

  decode_core u_decode_core (
    .i_instr (w_head.instr),
    .o_dec   (w_dec)
  );

  assign w_head_vld  = (r_count != '0) && rdy && !flush && !rst;
  assign w_unit_full = w_dec.slb ? in_slb_full : in_rs_full;
  assign w_issue     = w_head_vld && !w_dec.illegal && !in_rob_full && !w_unit_full;
  // Illegal heads are retired without a ROB slot, regardless of downstream back-pressure.
  assign w_deq       = w_issue || (w_head_vld && w_dec.illegal);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= '{instr: in_fetch_instr[INSTR_W-1:0], pc: in_fetch_pc, jump: in_fetch_jump};
  end

  assign out_reg_rs1  = w_head.instr[19:15];
  assign out_reg_rs2  = w_head.instr[24:20];
  assign out_rob_tag1 = in_reg_robtag1;
  assign out_rob_tag2 = in_reg_robtag2;

  function automatic opnd_t resolve(input logic uses, input logic busy,
                                    input logic [ROB_TAG_W-1:0] robtag, input logic rob_rdy,
                                    input logic [XLEN-1:0] reg_val, input logic [XLEN-1:0] rob_val);
    opnd_t r;
    r = '0;
    if (uses) begin
      if (!busy)       r.val = reg_val;
      else if (rob_rdy) r.val = rob_val;
      else             r.tag = robtag;
    end
    return r;
  endfunction

  always_comb begin
    w_src1 = resolve(w_dec.uses_rs1, in_reg_busy1, in_reg_robtag1, in_rob_ready1, in_reg_value1, in_rob_value1);
    w_src2 = resolve(w_dec.uses_rs2, in_reg_busy2, in_reg_robtag2, in_rob_ready2, in_reg_value2, in_rob_value2);
`ifdef DECODE_CDB_BYPASS_EN
    if (in_cdb_valid && (w_src1.tag != '0) && (w_src1.tag == in_cdb_tag)) begin
      w_src1.val = in_cdb_value;
      w_src1.tag = '0;
    end
    if (in_cdb_valid && (w_src2.tag != '0) && (w_src2.tag == in_cdb_tag)) begin
      w_src2.val = in_cdb_value;
      w_src2.tag = '0;
    end
`endif
  end

`ifndef DECODE_CDB_BYPASS_EN
  logic w_unused_cdb;
  assign w_unused_cdb = ^{in_cdb_valid, in_cdb_tag, in_cdb_value};
`endif

  always_comb begin
    out_issue_valid = w_issue;
    out_issue_slb   = 1'b0;
    out_op          = '0;
    out_value1      = '0;
    out_value2      = '0;
    out_tag1        = '0;
    out_tag2        = '0;
    out_imm         = '0;
    out_pc          = '0;
    out_rd          = '0;
    out_rob_tag     = '0;
    out_jump        = 1'b0;
    if (w_issue) begin
      out_issue_slb = w_dec.slb;
      out_op        = w_dec.op;
      out_value1    = w_src1.val;
      out_value2    = w_src2.val;
      out_tag1      = w_src1.tag;
      out_tag2      = w_src2.tag;
      out_imm       = XLEN'($signed(w_dec.imm));
      out_pc        = w_head.pc;
      out_rd        = w_dec.writes_rd ? w_head.instr[11:7] : 5'd0;
      out_rob_tag   = in_rob_freetag;
      out_jump      = w_head.jump;
    end
  end

endmodule
